// File: rtl/cam_pixel_writer.sv
// Camera byte-stream to RGB444 frame-buffer writer with 2:1 decimation and
// double-buffered banks that flip on every frame_end.
//
// state | meaning
// S_HI  | waiting for the first (high) byte of a pixel
// S_LO  | high byte latched, waiting for the matching low byte
module cam_pixel_writer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int DECIMATE = 2,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        pix_byte,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              pix_drop
);

  typedef enum logic {S_HI, S_LO} state_t;

  localparam int                SH       = (DECIMATE == 2) ? 1 : 0;
  localparam logic [10:0]       IMG_W_L  = 11'(IMG_W);
  localparam logic [10:0]       IMG_H_L  = 11'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(IMG_W / DECIMATE);

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              drop_q, drop_d;
  logic              pix_fire, wr_ok, byte_oor, keep;

  logic              p1_valid_q, p1_bank_q;
  logic [11:0]       p1_data_q;
  logic [ADDR_W-1:0] p1_base_q, p1_col_q;

  logic              wr_en_q, wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0]       wr_data_q;
  logic              bank_q, disp_bank_q, frame_done_q;
  logic [7:0]        frame_count_q;

  // Bits of RGB565 that RGB444 truncation throws away.
  logic              unused_bits;
  assign unused_bits = ^{hi_q[3], pix_byte[6:5], pix_byte[0]};

  assign byte_oor = ({1'b0, pix_x} >= IMG_W_L) || ({1'b0, pix_y} >= IMG_H_L);
  assign keep     = (DECIMATE == 1) || (!x_q[0] && !y_q[0]);
  assign wr_ok    = pix_fire && keep &&
                    ({1'b0, x_q} < IMG_W_L) && ({1'b0, y_q} < IMG_H_L);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    x_d      = x_q;
    y_d      = y_q;
    drop_d   = drop_q;
    pix_fire = 1'b0;
    if (frame_end) begin
      // frame_end wins over any byte and discards a half-assembled pixel.
      if (byte_valid || (state_q == S_LO)) drop_d = 1'b1;
      state_d = S_HI;
    end else if (byte_valid) begin
      if (byte_oor) drop_d = 1'b1;
      if ((state_q == S_LO) && (pix_x == x_q) && (pix_y == y_q)) begin
        pix_fire = 1'b1;
        state_d  = S_HI;
      end else begin
        if (state_q == S_LO) drop_d = 1'b1;
        hi_d    = pix_byte;
        x_d     = pix_x;
        y_d     = pix_y;
        state_d = S_LO;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_HI;
      hi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      drop_q        <= 1'b0;
      p1_valid_q    <= 1'b0;
      p1_bank_q     <= 1'b0;
      p1_data_q     <= '0;
      p1_base_q     <= '0;
      p1_col_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      bank_q        <= 1'b0;
      disp_bank_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      x_q        <= x_d;
      y_q        <= y_d;
      drop_q     <= drop_d;

      p1_valid_q <= wr_ok;
      if (wr_ok) begin
        p1_data_q <= {hi_q[7:4], hi_q[2:0], pix_byte[7], pix_byte[4:1]};
        p1_base_q <= ADDR_W'(y_q >> SH) * ROW_W;
        p1_col_q  <= ADDR_W'(x_q >> SH);
        p1_bank_q <= bank_q;
      end

      wr_en_q <= p1_valid_q;
      if (p1_valid_q) begin
        wr_addr_q <= p1_base_q + p1_col_q;
        wr_data_q <= p1_data_q;
        wr_bank_q <= p1_bank_q;
      end

      frame_done_q <= frame_end;
      if (frame_end) begin
        disp_bank_q   <= bank_q;
        bank_q        <= ~bank_q;
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_bank     = wr_bank_q;
  assign disp_bank   = disp_bank_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign pix_drop    = drop_q;

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Scoreboard bench for cam_pixel_writer: directed byte vectors push expected
// writes into a queue that a negedge monitor drains against wr_en.
module tb_cam_pixel_writer;

  localparam int ADDR_W = 17;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [11:0]       data;
    logic              bank;
  } wr_t;

  logic              pclk = 1'b0;
  logic              reset_n;
  logic              byte_valid;
  logic [7:0]        pix_byte;
  logic [9:0]        pix_x, pix_y;
  logic              frame_end;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              wr_bank, disp_bank, frame_done, pix_drop;
  logic [7:0]        frame_count;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  cam_pixel_writer #(.IMG_W(640), .IMG_H(480), .DECIMATE(2), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .reset_n(reset_n), .byte_valid(byte_valid), .pix_byte(pix_byte),
    .pix_x(pix_x), .pix_y(pix_y), .frame_end(frame_end), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank), .disp_bank(disp_bank),
    .frame_done(frame_done), .frame_count(frame_count), .pix_drop(pix_drop)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge pclk);
      if (wr_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%03h bank=%0b, expected no write",
                   wr_addr, wr_data, wr_bank);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data || wr_bank !== e.bank) begin
            n_bad++;
            $display("FAIL write: got addr=%0d data=0x%03h bank=%0b, expected addr=%0d data=0x%03h bank=%0b",
                     wr_addr, wr_data, wr_bank, e.addr, e.data, e.bank);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [9:0] x, input logic [9:0] y);
    byte_valid = 1'b1;
    pix_byte   = b;
    pix_x      = x;
    pix_y      = y;
    @(posedge pclk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [11:0] d, input logic bk);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.bank = bk;
    exp_q.push_back(e);
  endtask

  task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [9:0] x, input logic [9:0] y);
    send_byte(hi, x, y);
    send_byte(lo, x, y);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(posedge pclk);
    #1;
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    #2;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; byte_valid = 1'b0; frame_end = 1'b0;
    pix_byte = '0; pix_x = '0; pix_y = '0;
    idle(2);
    reset_n = 1'b1;
    check("rst_wr_en", wr_en, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_pix_drop", pix_drop, 0);
    check("rst_frame_done", frame_done, 0);

    // 1: red pixel at (4,2)
    expect_wr(17'd322, 12'hF00, 1'b0);
    send_pair(8'hF8, 8'h00, 10'd4, 10'd2);
    idle(3);

    // 2: even-x pixel kept, odd-x pixel silently discarded
    expect_wr(17'd3, 12'h0F0, 1'b0);
    send_pair(8'h07, 8'hE0, 10'd6, 10'd0);
    send_pair(8'h00, 8'h1F, 10'd3, 10'd0);
    idle(3);
    check("odd_x_no_drop", pix_drop, 0);

    // 3: frame_end while a write is in P2
    expect_wr(17'd324, 12'h14A, 1'b0);
    send_pair(8'h12, 8'h34, 10'd8, 10'd2);
    idle(1);
    pulse_fe();
    check("fe1_frame_done", frame_done, 1);
    check("fe1_disp_bank", disp_bank, 0);
    check("fe1_frame_count", frame_count, 1);
    idle(1);
    check("fe1_done_pulse", frame_done, 0);
    check("fe1_no_drop", pix_drop, 0);
    expect_wr(17'd0, 12'hFFF, 1'b1);
    send_pair(8'hFF, 8'hFF, 10'd0, 10'd0);
    idle(3);

    // 4: coordinate resync relatches the mismatching byte as a new first byte
    send_byte(8'hAB, 10'd10, 10'd4);
    send_byte(8'hCD, 10'd12, 10'd4);
    expect_wr(17'd646, 12'hCB7, 1'b1);
    send_byte(8'hEF, 10'd12, 10'd4);
    idle(3);
    check("resync_drop", pix_drop, 1);

    // frame_end in S_LO discards the partial pixel
    send_byte(8'h5A, 10'd20, 10'd6);
    pulse_fe();
    check("fe2_frame_count", frame_count, 2);
    check("fe2_disp_bank", disp_bank, 1);
    expect_wr(17'd970, 12'h800, 1'b0);
    send_pair(8'h80, 8'h00, 10'd20, 10'd6);
    idle(3);

    // frame_end with a byte in the same cycle drops the byte
    byte_valid = 1'b1; pix_byte = 8'h55; pix_x = 10'd2; pix_y = 10'd0;
    pulse_fe();
    byte_valid = 1'b0;
    check("fe3_frame_count", frame_count, 3);
    check("fe3_disp_bank", disp_bank, 0);
    expect_wr(17'd1, 12'h001, 1'b1);
    send_pair(8'h00, 8'h02, 10'd2, 10'd0);
    idle(3);

    // 5: out-of-range column, then frame counter wrap
    do_reset();
    check("rst2_frame_count", frame_count, 0);
    check("rst2_pix_drop", pix_drop, 0);
    send_byte(8'h00, 10'd640, 10'd0);
    idle(1);
    check("oor_drop", pix_drop, 1);
    send_byte(8'h11, 10'd640, 10'd0);
    idle(3);
    for (int i = 0; i < 256; i++) begin
      pulse_fe();
      if (i == 254) check("count_255", frame_count, 255);
      idle(1);
    end
    check("count_wrap", frame_count, 0);
    check("wrap_disp_bank", disp_bank, 1);
    expect_wr(17'd320, 12'hF07, 1'b0);
    send_pair(8'hF0, 8'h0F, 10'd0, 10'd2);
    idle(3);

    // 6: asynchronous reset mid-pixel with a write on the bus
    send_pair(8'h11, 8'h22, 10'd0, 10'd0);
    send_byte(8'hAA, 10'd2, 10'd0);
    check("pre_rst_wr_en", wr_en, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_disp_bank", disp_bank, 0);
    idle(1);
    reset_n = 1'b1;
    check("post_rst_pix_drop", pix_drop, 0);
    expect_wr(17'd1, 12'h362, 1'b0);
    send_pair(8'h33, 8'h44, 10'd2, 10'd0);
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_pixel_writer.md
Name: cam_pixel_writer

Overview:
Stage directly downstream of the camera capture block. Consumes the capture byte stream (RGB565, two bytes per pixel, tagged with x/y coordinates), assembles pixels, converts them to RGB444, optionally decimates 2:1, and writes them into a double-buffered BRAM frame buffer. At each frame end it flips the write bank and reports the completed bank to the display side.

Parameters:
IMG_W, 640, input image width in pixels
IMG_H, 480, input image height in lines
DECIMATE, 2, 1 = full resolution; 2 = keep even x and even y only
ADDR_W, 17, frame buffer address width; must cover (IMG_W/DECIMATE)*(IMG_H/DECIMATE)

Ports:
pclk  in  1  camera pixel clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
byte_valid  in  1  pix_byte, pix_x and pix_y are valid this cycle
pix_byte  in  8  camera byte
pix_x  in  10  pixel column of the byte
pix_y  in  10  pixel row of the byte
frame_end  in  1  single-cycle pulse, end of frame
wr_en  out  1  frame buffer write strobe
wr_addr  out  ADDR_W  write address within the bank
wr_data  out  12  RGB444 pixel {R4,G4,B4}
wr_bank  out  1  bank targeted by this write; aligned with wr_en
disp_bank  out  1  last completed bank, safe for the display to read
frame_done  out  1  one-cycle pulse after a frame closes
frame_count  out  8  completed-frame counter
pix_drop  out  1  sticky error flag

Behaviour:
- Reset (reset_n low, asynchronous): all outputs and registers go to 0. Write bank = 0, disp_bank = 0, FSM = S_HI, pipeline valids cleared. wr_en drops immediately. A partial pixel held at reset is lost, not written.
- FSM, S_HI (awaiting first byte):
  - On byte_valid: latch hi_byte, pix_x and pix_y; go to S_LO.
- FSM, S_LO (awaiting second byte), on byte_valid:
  - If pix_x/pix_y equal the latched values: form the pixel; go to S_HI.
  - Otherwise (resync): set pix_drop; treat this byte as a new first byte (relatch it); stay in S_LO.
- Byte format: hi = {R5, G6[5:3]}, lo = {G6[2:0], B5}. Conversion: R4 = R5[4:1], G4 = G6[5:2], B4 = B5[4:1] (truncate, no rounding).
- Pixel filter:
  - x ≥ IMG_W or y ≥ IMG_H: no write; set pix_drop.
  - DECIMATE = 2: write only when x[0] = 0 and y[0] = 0. Odd pixels are discarded silently.
- Address: wr_addr = (y/DECIMATE)*(IMG_W/DECIMATE) + x/DECIMATE. Use a constant multiply, shift/add permitted; no wrap within range.
- Pipeline: P1 registers the pixel, row base and bank; P2 adds the column and drives wr_en/wr_addr/wr_data/wr_bank. wr_en is high exactly 2 cycles after the accepting second byte. Throughput is 1 pixel per 2 bytes; no backpressure.
- frame_end handling:
  - Byte present in the same cycle: frame_end wins and the byte is dropped (pix_drop set).
  - FSM in S_LO: the partial pixel is discarded, pix_drop set, FSM returns to S_HI.
  - Pixels already in P1/P2 complete with their latched bank.
  - Next cycle: frame_done = 1, disp_bank = old write bank, write bank toggles, frame_count increments (wraps 255 → 0).
- A second frame_end with no pixels in between still toggles the bank and counts a frame.
- pix_drop clears only on reset.

Test Plan:
1. Reset, then bytes 0xF8, 0x00 at x=4, y=2 → 2 cycles after second byte: wr_en = 1 for one cycle, wr_addr = 322, wr_data = 0xF00, wr_bank = 0.
2. Pixels (0x07, 0xE0) at x=6, y=0 and (0x00, 0x1F) at x=3, y=0 → one write only: addr 3, data 0x0F0. The odd-x pixel produces no wr_en; pix_drop stays 0.
3. frame_end pulse while a pixel is in P2 → that write uses bank 0; next cycle frame_done = 1, disp_bank = 0, frame_count = 1; the following pixel writes with wr_bank = 1.
4. First byte at x=10, y=4, second byte at x=12, y=4 → no write from the first byte; pix_drop = 1; pixel formed with the next byte at x=12.
5. Byte at x=640, y=0 → no write, pix_drop = 1. After 256 frame_end pulses, frame_count = 0.
6. Deassert reset_n asynchronously mid-pixel (state S_LO, P1 valid) → wr_en = 0 with no clock edge; after release, FSM = S_HI, banks = 0, no spurious write.
